// File: rtl/wb_port_arbiter_if.sv
// Bundle of writeback request, register-file write and scoreboard signals
// shared between the two requesters, the issue stage and the arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned DW = 64
);
  logic          ex_valid;
  logic [4:0]    ex_addr;
  logic [DW-1:0] ex_data;
  logic          ex_ready;
  logic          lsu_valid;
  logic [4:0]    lsu_addr;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          iss_set;
  logic [4:0]    iss_addr;
  logic          w_ena;
  logic [4:0]    w_addr;
  logic [DW-1:0] w_data;
  logic [31:0]   busy_vec;

  // Requesters, issue stage and register file side.
  modport master (
    output ex_valid, ex_addr, ex_data, lsu_valid, lsu_addr, lsu_data, iss_set, iss_addr,
    input  ex_ready, lsu_ready, w_ena, w_addr, w_data, busy_vec
  );

  // Arbiter side.
  modport slave (
    input  ex_valid, ex_addr, ex_data, lsu_valid, lsu_addr, lsu_data, iss_set, iss_addr,
    output ex_ready, lsu_ready, w_ena, w_addr, w_data, busy_vec
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks onto one register-file
// write port, with a busy scoreboard of pending destination registers.
module wb_port_arbiter #(
  parameter int unsigned DW = 64
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {GrantEx, GrantLsu} grant_e;

  grant_e        last_grant_q, last_grant_d;
  logic          w_ena_q, w_ena_d;
  logic [4:0]    w_addr_q, w_addr_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [31:0]   busy_q, busy_d;

  logic          grant_ex, grant_lsu;
  logic          accept;
  logic [4:0]    acc_addr;
  logic [DW-1:0] acc_data;

  // Handshake: a lone requester wins outright; on conflict the one not granted last wins.
  always_comb begin
    grant_ex  = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      grant_ex  = bus.ex_valid  && (!bus.lsu_valid || last_grant_q == GrantLsu);
      grant_lsu = bus.lsu_valid && (!bus.ex_valid  || last_grant_q == GrantEx);
    end
  end

  assign bus.ex_ready  = grant_ex;
  assign bus.lsu_ready = grant_lsu;

  // Next-state for the grant pointer, the registered write beat and the scoreboard.
  always_comb begin
    last_grant_d = last_grant_q;
    w_ena_d      = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    busy_d       = busy_q;
    accept       = grant_ex || grant_lsu;
    acc_addr     = grant_ex ? bus.ex_addr : bus.lsu_addr;
    acc_data     = grant_ex ? bus.ex_data : bus.lsu_data;

    if (accept) begin
      last_grant_d = grant_ex ? GrantEx : GrantLsu;
      // Writes to x0 are swallowed: handshake completes but nothing reaches the port.
      if (acc_addr != 5'd0) begin
        w_ena_d  = 1'b1;
        w_addr_d = acc_addr;
        w_data_d = acc_data;
      end
    end

    // Clear first so a same-cycle set on the same register wins.
    if (w_ena_q) begin
      busy_d[w_addr_q] = 1'b0;
    end
    if (bus.iss_set) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset; reset also drops any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GrantLsu;
      w_ena_q      <= 1'b0;
      w_addr_q     <= 5'd0;
      w_data_q     <= '0;
      busy_q       <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      w_ena_q      <= w_ena_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.w_ena    = w_ena_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a cycle-level reference model is
// compared every cycle, and directed scenarios pin literal expectations.
module tb_wb_port_arbiter;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(DW)) bus ();

  wb_port_arbiter #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who won last, the write the port owes next cycle, and pending set.
  int            m_last_winner;  // 0 = ALU, 1 = LSU
  logic          m_wena;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;
  bit            m_busy [32];
  bit            m_live = 1'b0;

  function automatic bit m_ex_wins();
    if (rst || !bus.ex_valid) return 1'b0;
    if (!bus.lsu_valid) return 1'b1;
    return m_last_winner == 1;
  endfunction

  function automatic bit m_lsu_wins();
    if (rst || !bus.lsu_valid) return 1'b0;
    if (!bus.ex_valid) return 1'b1;
    return m_last_winner == 0;
  endfunction

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  always @(posedge clk) begin
    bit ex_w, lsu_w;
    ex_w  = m_ex_wins();
    lsu_w = m_lsu_wins();
    if (rst) begin
      m_last_winner = 1;
      m_wena  = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_live = 1'b1;
    end else begin
      if (m_wena) m_busy[m_waddr] = 1'b0;
      if (bus.iss_set && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
      if (ex_w || lsu_w) begin
        m_last_winner = ex_w ? 0 : 1;
        if ((ex_w ? bus.ex_addr : bus.lsu_addr) != 0) begin
          m_wena  = 1'b1;
          m_waddr = ex_w ? bus.ex_addr : bus.lsu_addr;
          m_wdata = ex_w ? bus.ex_data : bus.lsu_data;
        end else begin
          m_wena = 1'b0;
        end
      end else begin
        m_wena = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("ex_ready",  bus.ex_ready,  m_ex_wins());
      chk("lsu_ready", bus.lsu_ready, m_lsu_wins());
      chk("w_ena",     bus.w_ena,     m_wena);
      chk("w_addr",    bus.w_addr,    m_waddr);
      chk("w_data",    bus.w_data,    m_wdata);
      chk("busy_vec",  bus.busy_vec,  m_busy_word());
    end
  end

  // Drive one cycle of inputs just after the edge, return just after the next negedge.
  task automatic step(input logic r, input logic exv, input logic [4:0] exa,
                      input logic [63:0] exd, input logic lsv, input logic [4:0] lsa,
                      input logic [63:0] lsd, input logic iss, input logic [4:0] issa);
    @(posedge clk);
    #1;
    rst           = r;
    bus.ex_valid  = exv;
    bus.ex_addr   = exa;
    bus.ex_data   = exd;
    bus.lsu_valid = lsv;
    bus.lsu_addr  = lsa;
    bus.lsu_data  = lsd;
    bus.iss_set   = iss;
    bus.iss_addr  = issa;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  task automatic conflict(input logic [4:0] ea, input logic [4:0] la);
    step(1'b0, 1'b1, ea, 64'h100 + 64'(ea), 1'b1, la, 64'h200 + 64'(la), 1'b0, 5'd0);
  endtask

  initial begin
    bus.ex_valid = 0; bus.ex_addr = 0; bus.ex_data = 0;
    bus.lsu_valid = 0; bus.lsu_addr = 0; bus.lsu_data = 0;
    bus.iss_set = 0; bus.iss_addr = 0;

    // Reset with a request presented: readies low, nothing written afterwards.
    do_reset();
    step(1'b1, 1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'h10, 1'b0, 5'd0);
    chk("rst_ex_ready", bus.ex_ready, 1'b0);
    chk("rst_lsu_ready", bus.lsu_ready, 1'b0);
    chk("rst_busy", bus.busy_vec, 32'd0);
    idle();
    chk("rst_discard_w_ena", bus.w_ena, 1'b0);
    chk("rst_w_addr", bus.w_addr, 5'd0);

    // Lone ALU requester.
    step(1'b0, 1'b1, 5'd5, 64'hA5, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("lone_ex_ready", bus.ex_ready, 1'b1);
    idle();
    chk("lone_w_ena", bus.w_ena, 1'b1);
    chk("lone_w_addr", bus.w_addr, 5'd5);
    chk("lone_w_data", bus.w_data, 64'hA5);
    idle();
    chk("lone_w_ena_drop", bus.w_ena, 1'b0);
    chk("lone_w_addr_hold", bus.w_addr, 5'd5);

    // First conflict after reset: ex, lsu, ex.
    do_reset();
    conflict(5'd1, 5'd2);
    chk("cf1_ex_ready", bus.ex_ready, 1'b1);
    chk("cf1_lsu_ready", bus.lsu_ready, 1'b0);
    conflict(5'd1, 5'd2);
    chk("cf2_lsu_ready", bus.lsu_ready, 1'b1);
    chk("cf2_w_addr", bus.w_addr, 5'd1);
    conflict(5'd1, 5'd2);
    chk("cf3_ex_ready", bus.ex_ready, 1'b1);
    chk("cf3_w_addr", bus.w_addr, 5'd2);
    chk("cf3_w_data", bus.w_data, 64'h202);
    idle();
    chk("cf4_w_addr", bus.w_addr, 5'd1);
    chk("cf4_w_ena", bus.w_ena, 1'b1);

    // Address 0 from LSU: accepted, no write, but it becomes the last grant.
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0);
    chk("a0_lsu_ready", bus.lsu_ready, 1'b1);
    conflict(5'd4, 5'd6);
    chk("a0_w_ena", bus.w_ena, 1'b0);
    chk("a0_w_addr_hold", bus.w_addr, 5'd1);
    chk("a0_cf_ex_ready", bus.ex_ready, 1'b1);
    idle();
    chk("a0_cf_w_addr", bus.w_addr, 5'd4);

    // Scoreboard set, then cleared by the matching write.
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    step(1'b0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    chk("sb_busy7_set", bus.busy_vec[7], 1'b1);
    idle();
    chk("sb_w_addr7", bus.w_addr, 5'd7);
    chk("sb_busy7_wcycle", bus.busy_vec[7], 1'b1);
    idle();
    chk("sb_busy7_clear", bus.busy_vec, 32'd0);

    // Re-issue in the write cycle: set beats clear; x0 never goes busy.
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    step(1'b0, 1'b1, 5'd7, 64'h78, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    chk("sb_w_ena_reissue", bus.w_ena, 1'b1);
    chk("sb_busy0", bus.busy_vec[0], 1'b0);
    idle();
    chk("sb_busy7_kept", bus.busy_vec, 32'h80);

    // Reset in the middle of traffic.
    step(1'b0, 1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12);
    chk("mid_ex_ready", bus.ex_ready, 1'b1);
    step(1'b1, 1'b1, 5'd8, 64'h88, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0);
    chk("mid_rst_ex_ready", bus.ex_ready, 1'b0);
    chk("mid_rst_lsu_ready", bus.lsu_ready, 1'b0);
    conflict(5'd8, 5'd9);
    chk("mid_post_w_ena", bus.w_ena, 1'b0);
    chk("mid_post_busy", bus.busy_vec, 32'd0);
    chk("mid_post_ex_ready", bus.ex_ready, 1'b1);
    chk("mid_post_lsu_ready", bus.lsu_ready, 1'b0);
    idle();
    chk("mid_post_w_addr", bus.w_addr, 5'd8);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL use parameter DW, default 64, as the register data width (matches REG_BUS).
REQ-002 SHALL have clk input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have ex_valid input 1: ALU writeback request.
REQ-005 SHALL have ex_addr input 5: ALU destination register.
REQ-006 SHALL have ex_data input DW: ALU result.
REQ-007 SHALL have ex_ready output 1: ALU request accepted this cycle.
REQ-008 SHALL have lsu_valid input 1: load writeback request.
REQ-009 SHALL have lsu_addr input 5: load destination register.
REQ-010 SHALL have lsu_data input DW: load data.
REQ-011 SHALL have lsu_ready output 1: load request accepted this cycle.
REQ-012 SHALL have iss_set input 1: an issued instruction claims a destination.
REQ-013 SHALL have iss_addr input 5: the claimed destination.
REQ-014 SHALL have w_ena output 1: register-file write enable.
REQ-015 SHALL have w_addr output 5: register-file write address.
REQ-016 SHALL have w_data output DW: register-file write data.
REQ-017 SHALL have busy_vec output 32: bit i set means register i has a write pending.

Function
REQ-018 SHALL accept at most one request per cycle; a request is accepted when valid and ready are both high in the same cycle.
REQ-019 SHALL compute ready combinationally from the valids and the last_grant flop, with no combinational dependence on the data inputs.
REQ-020 SHALL grant a lone valid requester immediately, independent of last_grant.
REQ-021 SHALL, when both requesters are valid, grant the one not recorded in last_grant (round-robin).
REQ-022 SHALL update last_grant only on an accepted request.
REQ-023 SHALL register the accepted beat so that w_ena, w_addr and w_data present it exactly one cycle after acceptance (latency 1).
REQ-024 SHALL hold w_ena high for exactly one cycle per accepted beat.
REQ-025 SHALL drive w_ena low in any cycle that follows a cycle with no acceptance.
REQ-026 SHALL hold w_addr and w_data at their previous values while w_ena is low.
REQ-027 SHALL accept an address-0 request normally (ready high, last_grant updated) but drive w_ena low in the following cycle.
REQ-028 SHALL set busy bit iss_addr on iss_set, except for address 0.
REQ-029 SHALL clear busy bit w_addr in the cycle w_ena is high (busy drops at the clock edge ending that cycle).
REQ-030 SHALL let set win when iss_set targets the same address as a same-cycle clear.
REQ-031 SHALL hold busy_vec[0] at 0 permanently.
REQ-032 SHALL NOT use the busy state to gate the handshake; the scoreboard is status only.

Reset
REQ-033 SHALL, while rst is high at a clock edge, clear w_ena, w_addr, w_data and busy_vec to 0 and set last_grant to LSU.
REQ-034 SHALL force ex_ready and lsu_ready low while rst is high.
REQ-035 SHALL discard a request presented during a reset cycle, producing no write.
REQ-036 SHALL discard any beat in flight when rst is asserted, producing no w_ena after reset.
REQ-037 SHALL give ALU priority in the first conflict after reset (a consequence of last_grant = LSU).

Verification
REQ-038 SHALL cover lone requester: ex_valid=1, ex_addr=5, ex_data=0xA5 for one cycle -> ex_ready=1 that cycle; the next cycle w_ena=1, w_addr=5, w_data=0xA5; the cycle after, w_ena=0.
REQ-039 SHALL cover conflict after reset: both valid for 3 cycles with addresses 1 (ex) and 2 (lsu) -> grants ex, lsu, ex; w_addr sequence 1, 2, 1.
REQ-040 SHALL cover address 0: lsu_valid=1, lsu_addr=0 -> lsu_ready=1; the next cycle w_ena=0; a following conflict grants ex.
REQ-041 SHALL cover the scoreboard: iss_set addr 7, then an ex write to 7 -> busy_vec[7]=1 from the cycle after iss_set until the cycle after w_ena; iss_set addr 7 in the w_ena cycle -> bit stays 1.
REQ-042 SHALL cover reset mid-operation: accept beat addr 3, then rst high the next cycle -> w_ena=0, busy_vec=0, readies low; after rst drops, the first conflict grants ex.
